// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG coefficient block sequencer.
package jpeg_pkg;

  localparam int BLK_COEFS = 64;
  localparam int BLK_POS_W = 7;

  localparam int WIDTH_DEF = 16;
  localparam int RUNW_DEF  = 4;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

endpackage

// File: rtl/jpeg_coef_block_sequencer.sv
// Expands run-length coefficient symbols into a zigzag-ordered 64-word block and
// hands finished blocks downstream; assembly buffer and output register form a double buffer.
module jpeg_coef_block_sequencer
  import jpeg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RUNW  = RUNW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coef_valid,
  output logic                       coef_ready,
  input  logic [RUNW-1:0]            coef_run,
  input  logic [WIDTH-1:0]           coef_data,
  input  logic                       coef_eob,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [WIDTH*BLK_COEFS-1:0] blk_data,
  output logic                       blk_err,
  output logic                       busy
);

  logic [0:0]                 state;
  logic                       ready_en;
  logic [WIDTH-1:0]           abuf [BLK_COEFS];
  logic [BLK_POS_W-1:0]       pos;
  logic [BLK_POS_W-1:0]       tgt;
  logic                       aerr;
  logic                       accept;
  logic                       in_range;
  logic                       wr;
  logic                       ovf;
  logic                       done;
  logic                       o_free;
  logic                       load;
  logic [WIDTH*BLK_COEFS-1:0] a_next;

  assign coef_ready = ready_en && (state == ST_FILL);
  assign accept     = coef_valid && coef_ready;

  // 7-bit target position: pos+run never wraps, so overflow is a plain compare
  assign tgt      = pos + BLK_POS_W'(coef_run);
  assign in_range = tgt < BLK_POS_W'(BLK_COEFS);
  assign wr       = accept && !coef_eob && in_range;
  assign ovf      = accept && !coef_eob && !in_range;
  assign done     = accept && (coef_eob || ovf || (wr && tgt == BLK_POS_W'(BLK_COEFS - 1)));

  assign o_free = !blk_valid || blk_ready;
  assign load   = ((state == ST_FILL) && done && o_free) ||
                  ((state == ST_FULL) && blk_ready);

  assign busy = (pos != '0) || (state == ST_FULL);

  // Assembly contents including the write of the current symbol
  always_comb begin
    a_next = '0;
    for (int k = 0; k < BLK_COEFS; k++) begin
      if (wr && (tgt == BLK_POS_W'(k)))
        a_next[k*WIDTH +: WIDTH] = coef_data;
      else
        a_next[k*WIDTH +: WIDTH] = abuf[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FILL;
      ready_en  <= 1'b0;
      pos       <= '0;
      aerr      <= 1'b0;
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_err   <= 1'b0;
      for (int k = 0; k < BLK_COEFS; k++)
        abuf[k] <= '0;
    end else begin
      ready_en <= 1'b1;
      for (int k = 0; k < BLK_COEFS; k++)
        abuf[k] <= load ? '0 : a_next[k*WIDTH +: WIDTH];

      if (load) begin
        blk_data  <= a_next;
        blk_err   <= aerr | ovf;
        blk_valid <= 1'b1;
        pos       <= '0;
        aerr      <= 1'b0;
        state     <= ST_FILL;
      end else begin
        if (blk_ready)
          blk_valid <= 1'b0;
        if (wr)
          pos <= tgt + BLK_POS_W'(1);
        if (ovf)
          aerr <= 1'b1;
        // Completion while the output is still occupied parks the block in A
        if (done)
          state <= ST_FULL;
      end
    end
  end

endmodule
